// File: rtl/scan_mux_decoder_if.sv
// Bus bundle for scan_mux_decoder: selection controls and channel data in,
// registered selected data, one-hot enables, channel index and scan step out.
interface scan_mux_decoder_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4
) ();
   localparam int SEL_W = $clog2(CHANNELS);

   logic                      en;
   logic                      auto;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS-1:0]       skip_mask;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [WIDTH-1:0]          data_out;
   logic [CHANNELS-1:0]       ch_en;
   logic [SEL_W-1:0]          cur_ch;
   logic                      step;

   modport master (
      output en, auto, sel, skip_mask, data_in,
      input  data_out, ch_en, cur_ch, step
   );

   modport slave (
      input  en, auto, sel, skip_mask, data_in,
      output data_out, ch_en, cur_ch, step
   );
endinterface

// File: rtl/scan_mux_decoder.sv
// Registered N-channel mux with one-hot enable decoder and a prescaled
// round-robin scanner that skips masked channels; manual select otherwise.
module scan_mux_decoder #(
   parameter int WIDTH      = 4,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE   = 100000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   scan_mux_decoder_if.slave bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CHANNELS-1:0] CH_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [CNT_W-1:0]    count_q, count_d;
   logic [SEL_W-1:0]    cur_ch_q, cur_ch_d;
   logic [WIDTH-1:0]    data_out_q, data_out_d;
   logic [CHANNELS-1:0] ch_en_q, ch_en_d;
   logic                step_q, step_d;

   logic                tick_s;
   logic [SEL_W-1:0]    scan_ch_s;
   logic                scan_ok_s;
   logic                active_s;
   logic [CHANNELS-1:0] onehot_s;

   assign tick_s = (count_q == CNT_LAST);

   // Nearest unmasked channel after the current one; the downward loop keeps the closest hit.
   always_comb begin
      int idx;
      idx       = 0;
      scan_ch_s = cur_ch_q;
      scan_ok_s = !bus.skip_mask[cur_ch_q];
      for (int k = CHANNELS - 1; k >= 1; k--) begin
         idx = int'(cur_ch_q) + k;
         if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
         end else begin
            idx = idx;
         end
         if (!bus.skip_mask[idx]) begin
            scan_ch_s = SEL_W'(idx);
            scan_ok_s = 1'b1;
         end else begin
            scan_ok_s = scan_ok_s;
         end
      end
   end

   // Prescaler, channel pointer and step pulse next-state.
   always_comb begin
      count_d  = count_q;
      cur_ch_d = cur_ch_q;
      step_d   = 1'b0;
      if (!bus.en) begin
         count_d  = count_q;
         cur_ch_d = cur_ch_q;
      end else if (bus.auto) begin
         if (tick_s) begin
            count_d  = '0;
            cur_ch_d = scan_ch_s;
            step_d   = scan_ok_s;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end else begin
         count_d = '0;
         if (int'(bus.sel) < CHANNELS) begin
            cur_ch_d = bus.sel;
         end else begin
            cur_ch_d = cur_ch_q;
         end
      end
   end

   // Enable and data follow the next channel so all outputs agree on every edge.
   always_comb begin
      active_s   = bus.en && !bus.skip_mask[cur_ch_d];
      onehot_s   = '0;
      data_out_d = '0;
      if (active_s) begin
         onehot_s[cur_ch_d] = 1'b1;
         data_out_d         = bus.data_in[int'(cur_ch_d)*WIDTH +: WIDTH];
      end else begin
         data_out_d = '0;
      end
      ch_en_d = onehot_s ^ CH_IDLE;
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q    <= '0;
         cur_ch_q   <= '0;
         data_out_q <= '0;
         ch_en_q    <= CH_IDLE;
         step_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         cur_ch_q   <= cur_ch_d;
         data_out_q <= data_out_d;
         ch_en_q    <= ch_en_d;
         step_q     <= step_d;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.ch_en    = ch_en_q;
   assign bus.cur_ch   = cur_ch_q;
   assign bus.step     = step_q;
endmodule

// File: doc/scan_mux_decoder.md
Name: scan_mux_decoder

Overview:
Parametrised, clocked N-channel multiplexer with a built-in one-hot enable decoder and an automatic channel scanner. It selects one WIDTH-bit channel from CHANNELS packed inputs and drives the matching one-hot enable. Selection comes either from a manual select input or from a prescaled round-robin scan that can skip channels. It is the registered successor to the team's combinational mux/decoder blocks and drives time-multiplexed board outputs such as display digit scanning.

Parameters:
WIDTH, 4, bits per channel (>=1)
CHANNELS, 4, number of input channels (>=2; need not be a power of two)
SEL_W, $clog2(CHANNELS), derived select width; not overridden
PRESCALE, 100000, clock cycles per channel dwell in scan mode (>=1)
ACTIVE_LOW, 1, 1 = ch_en active-low, 0 = active-high

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  global enable (decoder E)
auto  in  1  1 = scan mode, 0 = manual mode
sel  in  SEL_W  manual channel select
skip_mask  in  CHANNELS  bit i = 1 excludes channel i
data_in  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
data_out  out  WIDTH  selected channel data, registered
ch_en  out  CHANNELS  one-hot channel enable, registered, polarity per ACTIVE_LOW
cur_ch  out  SEL_W  current channel index, registered
step  out  1  one-cycle pulse when scan advances

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Reset (immediate, no clock needed):
  - cur_ch = 0, prescaler = 0, data_out = 0, step = 0.
  - ch_en all inactive (all 1s if ACTIVE_LOW = 1, all 0s otherwise).
- Reset asserted mid-dwell aborts the scan. After release, scanning restarts at channel 0 with a full dwell.
- Prescaler: counts 0..PRESCALE-1 while en = 1 and auto = 1. tick = (count == PRESCALE-1), after which the counter wraps to 0.
  - The counter is held when en = 0.
  - The counter is cleared to 0 while auto = 0.
- Scan mode (auto = 1, en = 1):
  - On tick, cur_ch moves to the next channel circularly (CHANNELS-1 wraps to 0) whose skip_mask bit is 0.
  - If no other channel is unmasked but the current one is, cur_ch stays and step still pulses.
  - If all channels are masked, cur_ch holds and step stays 0.
- Manual mode (auto = 0, en = 1):
  - cur_ch <= sel every edge.
  - sel >= CHANNELS is ignored and cur_ch holds.
  - step = 0.
- en = 0: cur_ch holds, prescaler holds, data_out = 0, ch_en all inactive, step = 0. When en returns to 1, scanning resumes on the same channel with the remaining dwell.
- Output rule (single edge): cur_ch, ch_en and data_out all update on the same edge, computed from the next cur_ch value. There are no cycles where enable and data disagree.
  - ch_en[i] active iff en && i == next cur_ch && !skip_mask[i].
  - data_out = data_in slice of next cur_ch when that channel is active, else 0.
  - Latency: data_in change to data_out is 1 cycle.
- Mask change mid-dwell: the newly masked current channel goes inactive on the next edge. It is left at the next tick.
- Mode switches:
  - auto 1->0: cur_ch <= sel on the next edge.
  - auto 0->1: the dwell starts from count 0 on the current channel.
- step: registered, high exactly one cycle, on the edge where a tick-driven scan advance is loaded. It is never set by manual changes.

Test Plan:
1. Auto scan. Setup: PRESCALE=3, CHANNELS=4, WIDTH=4, ACTIVE_LOW=1; en=1, auto=1, mask=0000, data_in={D,C,B,A}. Required: cur_ch 0,1,2,3,0, each held 3 cycles; ch_en 1110,1101,1011,0111; data_out A,B,C,D; step pulses once every 3 cycles.
2. Skip mask=0110 -> cur_ch sequence 0,3,0,3; ch_en never shows 1101 or 1011; step pulses every 3 cycles.
3. Masking:
   - mask=1111 mid-scan -> ch_en=1111 and data_out=0 from the next edge; cur_ch frozen; step=0.
   - Then mask=0000 -> advance resumes at the next tick.
4. Manual mode:
   - auto=0, sel=2 -> next edge cur_ch=2, ch_en=1011, data_out=C.
   - data_in ch2 changes to 7 -> data_out=7 one cycle later.
   - With CHANNELS=3, sel=3 -> cur_ch unchanged.
5. Enable: en=0 at count 1 of channel 1 -> ch_en=1111, data_out=0. After 5 cycles set en=1 -> channel 1 shows for 2 more cycles, then advances to 2.
6. Reset: assert reset asynchronously mid-cycle during scan -> outputs at reset values immediately, without a clock edge. After release -> channel 0 dwells a full 3 cycles. Repeat with ACTIVE_LOW=0 -> idle ch_en=0000, active one-hot high.
